// File: rtl/fp32_adder.sv
// IEEE 754 binary32 adder, round-to-nearest-even, one output register stage.
// Define FADD_DENORM_EN for full subnormal support; otherwise subnormals flush to zero.
module fp32_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        out_valid
);
    logic [31:0] out_q, out_d;
    logic        valid_q;

    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]  ea, eb, e_big, e_sm, d;
    logic [23:0] ma, mb, m_big, m_sm, m_fin;
    logic        swap, s_big, rnd_up;
    logic [26:0] sm_raw, sm_shift, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  lim, shamt, e_norm, e_fin;
    logic [24:0] m_rnd;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    always_comb begin
        sa    = a[31];
        sb    = b[31];
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
`ifdef FADD_DENORM_EN
        // Subnormals carry hidden bit 0 and sit at exponent 1.
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        ea     = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb     = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma     = {|a[30:23], a[22:0]};
        mb     = {|b[30:23], b[22:0]};
`else
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        ea     = a[30:23];
        eb     = b[30:23];
        ma     = {1'b1, a[22:0]};
        mb     = {1'b1, b[22:0]};
`endif

        swap  = {eb, mb} > {ea, ma};
        s_big = swap ? sb : sa;
        e_big = swap ? eb : ea;
        e_sm  = swap ? ea : eb;
        m_big = swap ? mb : ma;
        m_sm  = swap ? ma : mb;
        d     = e_big - e_sm;

        // Align the smaller operand; bits shifted out collapse into the sticky position.
        sm_raw = {m_sm, 3'b000};
        if (d >= 8'd26)
            sm_shift = 27'd1;
        else
            sm_shift = (sm_raw >> d[4:0]) |
                       {26'd0, |(sm_raw & ~(27'h7FF_FFFF << d[4:0]))};

        if (sa ^ sb)
            sum = {1'b0, m_big, 3'b000} - {1'b0, sm_shift};
        else
            sum = {1'b0, m_big, 3'b000} + {1'b0, sm_shift};

        lz    = lzc27(sum[26:0]);
        lim   = {2'b00, e_big} - 10'd1;
        shamt = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
        if (sum[27]) begin
            norm   = {sum[27:2], sum[1] | sum[0]};
            e_norm = {2'b00, e_big} + 10'd1;
        end else begin
            norm   = sum[26:0] << shamt;
            e_norm = {2'b00, e_big} - shamt;
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        m_rnd  = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (m_rnd[24]) begin
            m_fin = m_rnd[24:1];
            e_fin = e_norm + 10'd1;
        end else begin
            m_fin = m_rnd[23:0];
            e_fin = e_norm;
        end

        if (a_nan)
            out_d = {a[31:23], 1'b1, a[21:0]};
        else if (b_nan)
            out_d = {b[31:23], 1'b1, b[21:0]};
        else if (a_inf && b_inf && (sa != sb))
            out_d = 32'hFFC0_0000;
        else if (a_inf)
            out_d = a;
        else if (b_inf)
            out_d = b;
        else if (a_zero && b_zero)
            out_d = {sa & sb, 31'd0};
        else if (a_zero)
            out_d = b;
        else if (b_zero)
            out_d = a;
        else if (sum == 28'd0)
            out_d = 32'h0000_0000;
        else if (e_fin >= 10'd255)
            out_d = {s_big, 8'hFF, 23'd0};
        else if (!m_fin[23])
`ifdef FADD_DENORM_EN
            out_d = {s_big, 8'h00, m_fin[22:0]};
`else
            out_d = {s_big, 31'd0};
`endif
        else
            out_d = {s_big, e_fin[7:0], m_fin[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid)
                out_q <= out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_fp32_adder.sv
// Directed-vector bench for fp32_adder with hand-computed binary32 results.
module tb_fp32_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic [31:0] out;
    logic        out_valid;
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] last_out;

    fp32_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_v);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check(tag, out, exp_v);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        last_out = exp_v;
    endtask

    task automatic idle_cycle(input string tag);
        a        = $urandom;
        b        = $urandom;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_hold"}, out, last_out);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h3F80_0000;
        b        = 32'h4000_0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, 32'h0000_0000);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;

        run_op("one_plus_zero", 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000);
        idle_cycle("idle1");
        idle_cycle("idle2");

        run_op("same_sign_1", 32'h4234_851F, 32'h427C_851F, 32'h42D8_851F);
        run_op("same_sign_2", 32'hC152_6666, 32'hC240_A3D7, 32'hC275_3D70);
        run_op("same_sign_3", 32'h4580_0000, 32'h4580_0000, 32'h4600_0000);
        run_op("same_sign_4", 32'h3ACA_62C1, 32'h3ACA_62C1, 32'h3B4A_62C1);
        run_op("tie_even_down", 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        run_op("tie_even_up", 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
        run_op("above_half", 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001);

        run_op("mixed_1", 32'h4049_999A, 32'hC166_3D71, 32'hC133_D70A);
        run_op("cancel", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
        run_op("near_cancel", 32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000);

        run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        run_op("x_plus_zero", 32'hC152_6666, 32'h0000_0000, 32'hC152_6666);
        run_op("zero_plus_x", 32'h8000_0000, 32'hC152_6666, 32'hC152_6666);
        run_op("negz_negz", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        run_op("posz_negz", 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        run_op("small_normal", 32'h0200_0000, 32'h0200_0000, 32'h0280_0000);
        run_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);

        run_op("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);
        run_op("inf_neginf", 32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000);
        run_op("neginf_inf", 32'hFF80_0000, 32'h7F80_0000, 32'hFFC0_0000);
        run_op("neginf_neginf", 32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000);
        run_op("neginf_finite", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
        run_op("inf_nan", 32'h7F80_0000, 32'h7F80_000D, 32'h7FC0_000D);
        run_op("finite_negnan", 32'h3F80_0000, 32'hFF80_0001, 32'hFFC0_0001);
        run_op("nan_a_first", 32'h7F80_0001, 32'h7FC0_0002, 32'h7FC0_0001);

`ifdef FADD_DENORM_EN
        run_op("sub_to_normal", 32'h0040_0000, 32'h0040_0000, 32'h0080_0000);
        run_op("sub_tiny", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
        run_op("sub_carry", 32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000);
        run_op("normal_to_sub", 32'h0080_0001, 32'h8080_0000, 32'h0000_0001);
`else
        run_op("sub_to_normal", 32'h0040_0000, 32'h0040_0000, 32'h0000_0000);
        run_op("sub_tiny", 32'h8000_0001, 32'h8000_0001, 32'h8000_0000);
        run_op("sub_plus_x", 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000);
        run_op("normal_to_sub", 32'h0080_0001, 32'h8080_0000, 32'h0000_0000);
`endif
        idle_cycle("idle3");

        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("reset2_out", out, 32'h0000_0000);
        check("reset2_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
